// File: rtl/avr_regfile_gen.sv
// rtl/avr_regfile_gen.sv - parametrised AVR register file with write-through bypass and clear sequencer
//
// Purpose: NREGS x DW register file with byte and register-pair (word) writes,
// a word/byte read port A, a byte read port B, write-through bypass on both
// read ports, and a sequencer that zeroes every register after reset or on
// clr_req while holding busy high.
//
// Ports:
//   clock    - master clock, rising edge
//   reset_n  - asynchronous active-low reset; restarts the clear sequence
//   waddr    - write address (waddr[0] selects the lane for byte writes)
//   wdata    - write data, low lane [DW-1:0], high lane [2*DW-1:DW]
//   we_byte  - byte write enable
//   we_word  - register-pair write enable, overrides we_byte
//   re_word  - port A returns the {odd, even} pair instead of one register
//   raddr_a  - port A read address
//   raddr_b  - port B read address
//   rdata_a  - port A read data (zero-extended for single-register reads)
//   rdata_b  - port B read data
//   clr_req  - one-cycle request to clear all registers
//   busy     - clear sequence in progress
module avr_regfile_gen #(
  parameter int NREGS = 32,
  parameter int DW    = 8,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [AW-1:0]   waddr,
  input  logic [2*DW-1:0] wdata,
  input  logic            we_byte,
  input  logic            we_word,
  input  logic            re_word,
  input  logic [AW-1:0]   raddr_a,
  input  logic [AW-1:0]   raddr_b,
  output logic [2*DW-1:0] rdata_a,
  output logic [DW-1:0]   rdata_b,
  input  logic            clr_req,
  output logic            busy
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  // One extra bit so the terminal compare never sees a wrapped index.
  localparam logic [AW:0] IDX_LAST = (AW+1)'(NREGS - 1);
  localparam logic [AW-1:0] LSB_ONE = AW'(1);

  logic [DW-1:0] regf [NREGS];

  logic [0:0]  state_q, state_d;
  logic [AW:0] idx_q, idx_d;

  logic          wr_ok;
  logic          lo_en, hi_en;
  logic [DW-1:0] lo_v, hi_v;
  logic [AW-1:0] w_even, w_odd;
  logic [AW-1:0] ra_even, ra_odd;
  logic [DW-1:0] a_lo, a_hi, a_one, b_one;

  // A read of register r sees the value being written to it this cycle, if any.
  function automatic logic [DW-1:0] bypass(
    input logic [AW-1:0] r,
    input logic [DW-1:0] stored,
    input logic [AW-1:0] wa,
    input logic          en_lo,
    input logic          en_hi,
    input logic [DW-1:0] val_lo,
    input logic [DW-1:0] val_hi
  );
    logic [DW-1:0] res;
    res = stored;
    if ((r >> 1) == (wa >> 1)) begin
      if (r[0] && en_hi) begin
        res = val_hi;
      end else if (!r[0] && en_lo) begin
        res = val_lo;
      end
    end
    return res;
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_CLEAR: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end
      end
      default: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign busy = (state_q == ST_CLEAR);

  // Writes presented alongside clr_req are dropped, so they are neither
  // committed nor bypassed.
  always_comb begin
    wr_ok  = !busy && !clr_req;
    lo_en  = wr_ok && (we_word || (we_byte && !waddr[0]));
    hi_en  = wr_ok && (we_word || (we_byte && waddr[0]));
    lo_v   = wdata[DW-1:0];
    hi_v   = we_word ? wdata[2*DW-1:DW] : wdata[DW-1:0];
    w_even = waddr & ~LSB_ONE;
    w_odd  = waddr | LSB_ONE;
  end

  always_ff @(posedge clock) begin
    if (busy) begin
      regf[idx_q[AW-1:0]] <= '0;
    end else begin
      if (lo_en) begin
        regf[w_even] <= lo_v;
      end
      if (hi_en) begin
        regf[w_odd] <= hi_v;
      end
    end
  end

  always_comb begin
    ra_even = raddr_a & ~LSB_ONE;
    ra_odd  = raddr_a | LSB_ONE;
    a_lo  = bypass(ra_even, regf[ra_even], waddr, lo_en, hi_en, lo_v, hi_v);
    a_hi  = bypass(ra_odd,  regf[ra_odd],  waddr, lo_en, hi_en, lo_v, hi_v);
    a_one = bypass(raddr_a, regf[raddr_a], waddr, lo_en, hi_en, lo_v, hi_v);
    b_one = bypass(raddr_b, regf[raddr_b], waddr, lo_en, hi_en, lo_v, hi_v);
    if (busy) begin
      rdata_a = '0;
      rdata_b = '0;
    end else begin
      rdata_a = re_word ? {a_hi, a_lo} : {{DW{1'b0}}, a_one};
      rdata_b = b_one;
    end
  end

endmodule

// File: tb/tb_avr_regfile_gen.sv
// tb/tb_avr_regfile_gen.sv - randomized and directed bench for avr_regfile_gen
module tb_avr_regfile_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- instance 0: NREGS=32, DW=8 ----------------
  logic        rst0_n = 1'b1;
  logic [4:0]  waddr0 = '0, ra0 = '0, rb0 = '0;
  logic [15:0] wdata0 = '0;
  logic        wb0 = 0, ww0 = 0, re0 = 0, clr0 = 0;
  logic [15:0] rdata_a0;
  logic [7:0]  rdata_b0;
  logic        busy0;

  avr_regfile_gen #(.NREGS(32), .DW(8)) dut0 (
    .clock(clk), .reset_n(rst0_n), .waddr(waddr0), .wdata(wdata0),
    .we_byte(wb0), .we_word(ww0), .re_word(re0), .raddr_a(ra0), .raddr_b(rb0),
    .rdata_a(rdata_a0), .rdata_b(rdata_b0), .clr_req(clr0), .busy(busy0)
  );

  // ---------------- instance 1: NREGS=16, DW=16 ----------------
  logic        rst1_n = 1'b1;
  logic [3:0]  waddr1 = '0, ra1 = '0, rb1 = '0;
  logic [31:0] wdata1 = '0;
  logic        wb1 = 0, ww1 = 0, re1 = 0, clr1 = 0;
  logic [31:0] rdata_a1;
  logic [15:0] rdata_b1;
  logic        busy1;

  avr_regfile_gen #(.NREGS(16), .DW(16)) dut1 (
    .clock(clk), .reset_n(rst1_n), .waddr(waddr1), .wdata(wdata1),
    .we_byte(wb1), .we_word(ww1), .re_word(re1), .raddr_a(ra1), .raddr_b(rb1),
    .rdata_a(rdata_a1), .rdata_b(rdata_b1), .clr_req(clr1), .busy(busy1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of instance 0 ----------------
  // Clearing is modelled as "contents become zero, outputs read zero for 32 cycles".
  logic [7:0] mem0 [32];
  bit         m_busy = 1'b1;
  int         m_cnt  = 32;
  bit         chk0   = 1'b0;

  // Contents of register r as they will be after this cycle's edge; a
  // write-through read returns exactly this.
  function automatic logic [7:0] post0(input int r);
    if (!clr0) begin
      if (ww0 && (r / 2) == (int'(waddr0) / 2))
        return (r % 2 == 1) ? wdata0[15:8] : wdata0[7:0];
      if (!ww0 && wb0 && r == int'(waddr0))
        return wdata0[7:0];
    end
    return mem0[r];
  endfunction

  always @(posedge clk or negedge rst0_n) begin
    logic [7:0] tmp [32];
    if (!rst0_n) begin
      m_busy = 1'b1;
      m_cnt  = 32;
      for (int r = 0; r < 32; r++) mem0[r] = 8'h00;
    end else if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) m_busy = 1'b0;
    end else if (clr0) begin
      m_busy = 1'b1;
      m_cnt  = 32;
      for (int r = 0; r < 32; r++) mem0[r] = 8'h00;
    end else begin
      for (int r = 0; r < 32; r++) tmp[r] = post0(r);
      for (int r = 0; r < 32; r++) mem0[r] = tmp[r];
    end
  end

  always @(negedge clk) begin
    logic [15:0] ea;
    logic [7:0]  eb;
    if (chk0) begin
      if (m_busy) begin
        ea = '0;
        eb = '0;
      end else begin
        ea = re0 ? {post0(int'(ra0) | 1), post0(int'(ra0) & ~1)} : {8'h00, post0(int'(ra0))};
        eb = post0(int'(rb0));
      end
      check("model_busy0", 64'(busy0), 64'(m_busy));
      check("model_rdata_a0", 64'(rdata_a0), 64'(ea));
      check("model_rdata_b0", 64'(rdata_b0), 64'(eb));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt0, cnt1;
    for (int r = 0; r < 32; r++) mem0[r] = 8'h00;
    #1;
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    #1;
    chk0 = 1'b1;
    check("reset_busy0", 64'(busy0), 64'd1);
    check("reset_rdata_a0", 64'(rdata_a0), 64'd0);
    check("reset_busy1", 64'(busy1), 64'd1);
    step();
    step();
    rst0_n = 1'b1;
    rst1_n = 1'b1;

    // Busy length after reset release, both parameter sets.
    cnt0 = 0;
    cnt1 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy0) cnt0++;
      if (busy1) cnt1++;
    end
    check("busy_len_reset0", 64'(cnt0), 64'd32);
    check("busy_len_reset1", 64'(cnt1), 64'd16);

    for (int r = 0; r < 32; r++) begin
      step();
      re0 = 1'b0;
      ra0 = 5'(r);
      rb0 = 5'(r);
      @(negedge clk);
      check("cleared_a0", 64'(rdata_a0), 64'd0);
      check("cleared_b0", 64'(rdata_b0), 64'd0);
    end

    // Word write then pair read.
    step();
    ww0 = 1'b1; waddr0 = 5'd5; wdata0 = 16'hBEEF;
    step();
    ww0 = 1'b0; re0 = 1'b1; ra0 = 5'd4; rb0 = 5'd4;
    @(negedge clk);
    check("word_pair_a0", 64'(rdata_a0), 64'hBEEF);
    check("word_even_b0", 64'(rdata_b0), 64'hEF);
    rb0 = 5'd5;
    #1;
    check("word_odd_b0", 64'(rdata_b0), 64'hBE);

    // Byte write to the odd register leaves the even one alone.
    step();
    wb0 = 1'b1; waddr0 = 5'd7; wdata0 = 16'h1234;
    step();
    wb0 = 1'b0; re0 = 1'b0; ra0 = 5'd7;
    @(negedge clk);
    check("byte_odd_a0", 64'(rdata_a0), 64'h0034);
    ra0 = 5'd6;
    #1;
    check("byte_even_untouched_a0", 64'(rdata_a0), 64'h0000);

    // Same-cycle bypass.
    step();
    ww0 = 1'b1; waddr0 = 5'd2; wdata0 = 16'hA55A; re0 = 1'b1; ra0 = 5'd2; rb0 = 5'd3;
    @(negedge clk);
    check("bypass_a0", 64'(rdata_a0), 64'hA55A);
    check("bypass_b0", 64'(rdata_b0), 64'hA5);
    step();
    ww0 = 1'b0;

    // Reset mid-clear at idx=10 restarts a full clear.
    rst0_n = 1'b0;
    step();
    rst0_n = 1'b1;
    repeat (10) step();
    check("midclear_busy0", 64'(busy0), 64'd1);
    rst0_n = 1'b0;
    step();
    rst0_n = 1'b1;
    cnt0 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy0) cnt0++;
    end
    check("busy_len_midclear0", 64'(cnt0), 64'd32);

    // Load registers, including register 9.
    for (int i = 0; i < 40; i++) begin
      step();
      ww0 = ($urandom_range(0, 1) == 1);
      wb0 = !ww0;
      waddr0 = (i == 0) ? 5'd9 : 5'($urandom);
      wdata0 = 16'($urandom) | 16'h0101;
    end
    step();
    ww0 = 1'b0; wb0 = 1'b0; re0 = 1'b0; ra0 = 5'd9;
    @(negedge clk);
    check("loaded_reg9_nonzero0", 64'(rdata_a0 != 16'h0), 64'd1);

    // clr_req with a simultaneous word write to pair 0 (dropped).
    step();
    clr0 = 1'b1; ww0 = 1'b1; waddr0 = 5'd0; wdata0 = 16'h1111;
    step();
    clr0 = 1'b0; ww0 = 1'b0;
    wb0 = 1'b1; waddr0 = 5'd9; wdata0 = 16'h0077;
    cnt0 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy0) cnt0++;
      if (i == 2) begin
        wb0 = 1'b0;
        clr0 = 1'b1;
      end
      if (i == 3) clr0 = 1'b0;
    end
    check("busy_len_clr0", 64'(cnt0), 64'd32);
    re0 = 1'b1; ra0 = 5'd0; rb0 = 5'd9;
    #1;
    check("clr_drop_word_a0", 64'(rdata_a0), 64'h0000);
    check("clr_drop_busywrite_b0", 64'(rdata_b0), 64'h00);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step();
      ww0    = ($urandom_range(0, 3) == 0);
      wb0    = ($urandom_range(0, 2) == 0);
      re0    = $urandom_range(0, 1) == 1;
      waddr0 = 5'($urandom);
      wdata0 = 16'($urandom);
      ra0    = 5'($urandom);
      rb0    = ($urandom_range(0, 1) == 1) ? waddr0 : 5'($urandom);
      clr0   = ($urandom_range(0, 99) == 0);
    end
    step();
    ww0 = 1'b0; wb0 = 1'b0; clr0 = 1'b0;

    // Second parameter set: word write, bypass, clear.
    step();
    ww1 = 1'b1; waddr1 = 4'd5; wdata1 = 32'hDEADBEEF;
    step();
    ww1 = 1'b0; re1 = 1'b1; ra1 = 4'd4; rb1 = 4'd4;
    @(negedge clk);
    check("word_pair_a1", 64'(rdata_a1), 64'hDEADBEEF);
    check("word_even_b1", 64'(rdata_b1), 64'hBEEF);
    rb1 = 4'd5; re1 = 1'b0; ra1 = 4'd5;
    #1;
    check("word_odd_b1", 64'(rdata_b1), 64'hDEAD);
    check("single_odd_a1", 64'(rdata_a1), 64'h0000DEAD);
    step();
    ww1 = 1'b1; waddr1 = 4'd3; wdata1 = 32'h12345678; re1 = 1'b1; ra1 = 4'd2; rb1 = 4'd2;
    @(negedge clk);
    check("bypass_a1", 64'(rdata_a1), 64'h12345678);
    check("bypass_b1", 64'(rdata_b1), 64'h5678);
    step();
    ww1 = 1'b0; clr1 = 1'b1;
    step();
    clr1 = 1'b0;
    cnt1 = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy1) cnt1++;
    end
    check("busy_len_clr1", 64'(cnt1), 64'd16);
    re1 = 1'b1; ra1 = 4'd4; rb1 = 4'd3;
    #1;
    check("cleared_a1", 64'(rdata_a1), 64'h0);
    check("cleared_b1", 64'(rdata_b1), 64'h0);

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/avr_regfile_gen.md
Name: avr_regfile_gen

Overview:
- Parametrised next-generation register file for the AVR-compatible CPU core.
- Generalises register count and data width; keeps the byte/word-pair write and read semantics.
- Adds a write-through bypass on both read ports.
- Adds a hardware clear sequencer that zeroes every register after reset or on request, signalling busy while it runs.

Parameters:
- NREGS, 32, number of registers; must be an even power of two, at least 2.
- DW, 8, register width in bits.
- AW, log2(NREGS), address width; localparam, not overridable.

Ports:
- clock  input  1  master clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- waddr  input  AW  write address.
- wdata  input  2*DW  write data; low lane [DW-1:0], high lane [2*DW-1:DW].
- we_byte  input  1  byte write enable.
- we_word  input  1  word (register pair) write enable.
- re_word  input  1  port A word read enable.
- raddr_a  input  AW  port A read address.
- raddr_b  input  AW  port B read address.
- rdata_a  output  2*DW  port A read data.
- rdata_b  output  DW  port B read data.
- clr_req  input  1  single-cycle request to clear all registers.
- busy  output  1  clear sequence in progress.

Behaviour:
- Storage: NREGS x DW array with no reset on the array itself; the clear FSM initialises it.
- Pair addressing: pair base = {addr[AW-1:1],0}; low register = even index, high register = odd index.
- Byte write (we_byte=1, we_word=0): waddr[0]=0 writes wdata low lane to the even register; waddr[0]=1 writes wdata low lane to the odd register.
- Word write (we_word=1): low lane to the even register and high lane to the odd register of the pair; waddr[0] is ignored. we_word overrides we_byte.
- Writes commit on the rising clock edge. There is no write when both enables are 0.
- Port A read, combinational:
  - re_word=1: {odd register, even register} of the raddr_a pair.
  - re_word=0: zero-extended register raddr_a.
- Port B read, combinational: register raddr_b.
- Bypass: if a write is enabled this cycle and a read address hits a register being written, that lane returns the incoming write value (per the byte/word lane rules above), not the stored value. This applies per lane and per port.
- Clear FSM states:
  - CLEAR: index idx from 0 to NREGS-1; writes 0 to regf[idx] each cycle.
  - IDLE: normal operation.
- Reset (reset_n=0, asynchronous): state=CLEAR, idx=0, busy=1. The clear starts on the first clock after deassertion.
- CLEAR: idx increments every cycle. The cycle that writes idx=NREGS-1 moves to IDLE on that edge, so busy=1 for exactly NREGS cycles after reset release.
- IDLE with clr_req=1: moves to CLEAR, idx=0, busy=1 on the next edge. Any write presented in the same cycle as clr_req is dropped.
- clr_req while busy: ignored; the sequence does not restart.
- While busy: we_byte and we_word are ignored, rdata_a=0, rdata_b=0, and bypass is disabled.
- reset_n asserted mid-clear or mid-operation: immediate return to CLEAR with idx=0, and a full clear runs again.
- Outputs after reset: busy=1, rdata_a=0, rdata_b=0.
- Address arithmetic: idx is AW+1 bits wide, so there is no wrap before the terminal compare.

Test Plan:
- Reset release, NREGS=32, DW=8 -> busy=1 for exactly 32 cycles, then 0; read every address, re_word=0 -> all rdata 0.
- Word write waddr=5, wdata=16'hBEEF, then re_word=1, raddr_a=4 -> rdata_a=16'hBEEF; raddr_b=4 -> 8'hEF; raddr_b=5 -> 8'hBE.
- Byte write waddr=7, wdata=16'h1234, then re_word=0, raddr_a=7 -> rdata_a=16'h0034; raddr_a=6 -> 16'h0000 (register 6 unchanged).
- Same-cycle word write waddr=2, wdata=16'hA55A with raddr_a=2, re_word=1 and raddr_b=3 -> rdata_a=16'hA55A and rdata_b=8'hA5 in that same cycle.
- Registers loaded, clr_req pulse plus simultaneous word write to 0 -> busy for 32 cycles; a write during busy to register 9 is dropped; afterwards all registers read 0.
- reset_n pulsed low mid-clear at idx=10 -> busy stays 1 for a full 32 cycles after release; second parameter set NREGS=16, DW=16 repeats the word-write and clear checks with 32-bit rdata_a.
